// File: rtl/io_char_fifo.sv
// Terminal character buffering between an external device and the CPU: one FIFO per direction,
// with FGI/FGO flags, a sticky overflow flag and an interrupt request for the I/O instructions.

module io_char_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         push_req,
    input  logic [W-1:0] push_data,
    input  logic         pop_req,
    output logic [W-1:0] head,
    output logic [PW:0]  count,
    output logic         full,
    output logic         empty
);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push, pop;

    // Full/empty come from the registered count, so a pop never makes room for a same-cycle push.
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign push  = push_req & ~full;
    assign pop   = pop_req & ~empty;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (CLR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately left unreset; the reset pointers and count make old contents invisible.
    always_ff @(posedge CLK) begin
        if (push && !CLR) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

module io_char_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         ext_in_valid,
    input  logic [W-1:0] ext_in_data,
    output logic         ext_in_ready,
    input  logic         INP_LD,
    output logic [W-1:0] INPR_out,
    output logic         FGI,
    input  logic         OUT_LD,
    input  logic [W-1:0] OUTR_in,
    output logic         FGO,
    output logic         ext_out_valid,
    output logic [W-1:0] ext_out_data,
    input  logic         ext_out_ready,
    input  logic         IEN,
    output logic         IRQ,
    output logic [PW:0]  in_count,
    output logic [PW:0]  out_count,
    output logic         ovf
);
    logic in_full, in_empty, out_full, out_empty;
    logic ovf_q, ovf_d;

    io_char_fifo_buf #(.W(W), .DEPTH(DEPTH)) u_in_fifo (
        .CLK       (CLK),
        .CLR       (CLR),
        .push_req  (ext_in_valid),
        .push_data (ext_in_data),
        .pop_req   (INP_LD),
        .head      (INPR_out),
        .count     (in_count),
        .full      (in_full),
        .empty     (in_empty)
    );

    io_char_fifo_buf #(.W(W), .DEPTH(DEPTH)) u_out_fifo (
        .CLK       (CLK),
        .CLR       (CLR),
        .push_req  (OUT_LD),
        .push_data (OUTR_in),
        .pop_req   (ext_out_ready),
        .head      (ext_out_data),
        .count     (out_count),
        .full      (out_full),
        .empty     (out_empty)
    );

    assign ext_in_ready  = ~in_full;
    assign FGI           = ~in_empty;
    assign FGO           = ~out_full;
    assign ext_out_valid = ~out_empty;
    assign IRQ           = IEN & (FGI | FGO);
    assign ovf           = ovf_q;

    always_comb begin
        ovf_d = ovf_q | (ext_in_valid & in_full) | (OUT_LD & out_full);
    end

    always_ff @(posedge CLK) begin
        if (CLR) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end
endmodule
